// File: rtl/cmp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_pipe
//  Description : Joins two operand streams, applies an elaboration-selected
//                comparison, and buffers the 1-bit results in a 2-entry FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_pipe #(
    parameter int TDIN0       = 16,
    parameter int TDIN1       = 16,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 0,
    parameter int OP          = 0,
    parameter int INVERT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TDIN0-1:0] din0_data,
    input  logic             din0_valid,
    output logic             din0_ready,
    input  logic [TDIN1-1:0] din1_data,
    input  logic             din1_valid,
    output logic             din1_ready,
    output logic             dout_data,
    output logic             dout_valid,
    input  logic             dout_ready
);

    // One guard bit makes a zero-extended unsigned operand safe to compare signed.
    localparam int c_w     = ((TDIN0 > TDIN1) ? TDIN0 : TDIN1) + 1;
    localparam int c_op_eq = 0;
    localparam int c_op_ne = 1;
    localparam int c_op_lt = 2;
    localparam int c_op_le = 3;
    localparam int c_op_gt = 4;
    localparam int c_op_ge = 5;

    generate
        if (OP < c_op_eq || OP > c_op_ge) begin : g_op_invalid
            $error("cmp_pipe: OP must be in the range 0..5");
        end
    endgenerate

    logic signed [c_w-1:0] w_a;
    logic signed [c_w-1:0] w_b;
    logic                  w_cmp;
    logic                  w_res;
    logic                  w_push;
    logic                  w_pop;

    logic [1:0]            r_count;
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_mem;

    generate
        if (DIN0_SIGNED != 0) begin : g_a_sext
            assign w_a = {{(c_w-TDIN0){din0_data[TDIN0-1]}}, din0_data};
        end else begin : g_a_zext
            assign w_a = {{(c_w-TDIN0){1'b0}}, din0_data};
        end
        if (DIN1_SIGNED != 0) begin : g_b_sext
            assign w_b = {{(c_w-TDIN1){din1_data[TDIN1-1]}}, din1_data};
        end else begin : g_b_zext
            assign w_b = {{(c_w-TDIN1){1'b0}}, din1_data};
        end
    endgenerate

    always_comb begin
        w_cmp = 1'b0;
        case (OP)
            c_op_eq: w_cmp = (w_a == w_b);
            c_op_ne: w_cmp = (w_a != w_b);
            c_op_lt: w_cmp = (w_a <  w_b);
            c_op_le: w_cmp = (w_a <= w_b);
            c_op_gt: w_cmp = (w_a >  w_b);
            c_op_ge: w_cmp = (w_a >= w_b);
            default: w_cmp = 1'b0;
        endcase
        w_res = w_cmp ^ (INVERT != 0);
    end

    // A full buffer refuses input even when it is draining, so ready never sees dout_ready.
    assign w_push     = din0_valid & din1_valid & (r_count != 2'd2) & ~rst;
    assign w_pop      = (r_count != 2'd0) & dout_ready;
    assign din0_ready = w_push;
    assign din1_ready = w_push;
    assign dout_valid = (r_count != 2'd0);
    assign dout_data  = r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_mem   <= 2'b00;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_res;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cmp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_pipe
//  Description : Scoreboard bench driving seven cmp_pipe configurations in
//                lockstep from shared operand and handshake signals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a   = '0;
    logic [15:0] b   = '0;
    logic        v0  = 1'b0;
    logic        v1  = 1'b0;
    logic        rdy = 1'b0;
    logic [6:0]  rd0;
    logic [6:0]  rd1;
    logic [6:0]  ov;
    logic [6:0]  od;
    logic [6:0]  ecur = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pops0  = 0;

    bit   sbq [7][$];
    logic mexp;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [6:0]  e;
    } vec_t;

    // e bits, MSB first: u6 s8>=u8, u5 s8<=s8, u4 s4<u12, u3 !(u8==s8),
    // u2 u8==s8, u1 u8>s8, u0 u8==u8.
    vec_t vt [8] = '{
        '{16'h005A, 16'h005A, 7'b1110101},
        '{16'h005A, 16'h005B, 7'b0111000},
        '{16'h00FF, 16'h00FF, 7'b0111011},
        '{16'h0008, 16'h0000, 7'b1011010},
        '{16'h0007, 16'h0FFF, 7'b0011010},
        '{16'h0080, 16'h007F, 7'b0111010},
        '{16'h007F, 16'h0080, 7'b0011010},
        '{16'h0000, 16'h0000, 7'b1100101}
    };

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmp_pipe #(.TDIN0(8), .TDIN1(8), .DIN0_SIGNED(0), .DIN1_SIGNED(0), .OP(0), .INVERT(0)) u0 (
        .clk(clk), .rst(rst),
        .din0_data(a[7:0]), .din0_valid(v0), .din0_ready(rd0[0]),
        .din1_data(b[7:0]), .din1_valid(v1), .din1_ready(rd1[0]),
        .dout_data(od[0]), .dout_valid(ov[0]), .dout_ready(rdy));
    cmp_pipe #(.TDIN0(8), .TDIN1(8), .DIN0_SIGNED(0), .DIN1_SIGNED(1), .OP(4), .INVERT(0)) u1 (
        .clk(clk), .rst(rst),
        .din0_data(a[7:0]), .din0_valid(v0), .din0_ready(rd0[1]),
        .din1_data(b[7:0]), .din1_valid(v1), .din1_ready(rd1[1]),
        .dout_data(od[1]), .dout_valid(ov[1]), .dout_ready(rdy));
    cmp_pipe #(.TDIN0(8), .TDIN1(8), .DIN0_SIGNED(0), .DIN1_SIGNED(1), .OP(0), .INVERT(0)) u2 (
        .clk(clk), .rst(rst),
        .din0_data(a[7:0]), .din0_valid(v0), .din0_ready(rd0[2]),
        .din1_data(b[7:0]), .din1_valid(v1), .din1_ready(rd1[2]),
        .dout_data(od[2]), .dout_valid(ov[2]), .dout_ready(rdy));
    cmp_pipe #(.TDIN0(8), .TDIN1(8), .DIN0_SIGNED(0), .DIN1_SIGNED(1), .OP(0), .INVERT(1)) u3 (
        .clk(clk), .rst(rst),
        .din0_data(a[7:0]), .din0_valid(v0), .din0_ready(rd0[3]),
        .din1_data(b[7:0]), .din1_valid(v1), .din1_ready(rd1[3]),
        .dout_data(od[3]), .dout_valid(ov[3]), .dout_ready(rdy));
    cmp_pipe #(.TDIN0(4), .TDIN1(12), .DIN0_SIGNED(1), .DIN1_SIGNED(0), .OP(2), .INVERT(0)) u4 (
        .clk(clk), .rst(rst),
        .din0_data(a[3:0]), .din0_valid(v0), .din0_ready(rd0[4]),
        .din1_data(b[11:0]), .din1_valid(v1), .din1_ready(rd1[4]),
        .dout_data(od[4]), .dout_valid(ov[4]), .dout_ready(rdy));
    cmp_pipe #(.TDIN0(8), .TDIN1(8), .DIN0_SIGNED(1), .DIN1_SIGNED(1), .OP(3), .INVERT(0)) u5 (
        .clk(clk), .rst(rst),
        .din0_data(a[7:0]), .din0_valid(v0), .din0_ready(rd0[5]),
        .din1_data(b[7:0]), .din1_valid(v1), .din1_ready(rd1[5]),
        .dout_data(od[5]), .dout_valid(ov[5]), .dout_ready(rdy));
    cmp_pipe #(.TDIN0(8), .TDIN1(8), .DIN0_SIGNED(1), .DIN1_SIGNED(0), .OP(5), .INVERT(0)) u6 (
        .clk(clk), .rst(rst),
        .din0_data(a[7:0]), .din0_valid(v0), .din0_ready(rd0[6]),
        .din1_data(b[7:0]), .din1_valid(v1), .din1_ready(rd1[6]),
        .dout_data(od[6]), .dout_valid(ov[6]), .dout_ready(rdy));

    function automatic int sx(input logic [15:0] v, input int w, input bit s);
        int u;
        u = int'(v) & ((1 << w) - 1);
        if (s && v[w-1]) return u - (1 << w);
        return u;
    endfunction

    function automatic bit model(input int k, input logic [15:0] xa, input logic [15:0] xb);
        int w0, w1, op;
        bit s0, s1, inv, r;
        int x, y;
        w0 = 8; w1 = 8; s0 = 0; s1 = 0; op = 0; inv = 0;
        case (k)
            1: begin s1 = 1; op = 4; end
            2: begin s1 = 1; end
            3: begin s1 = 1; inv = 1; end
            4: begin w0 = 4; s0 = 1; w1 = 12; op = 2; end
            5: begin s0 = 1; s1 = 1; op = 3; end
            6: begin s0 = 1; op = 5; end
            default: ;
        endcase
        x = sx(xa, w0, s0);
        y = sx(xb, w1, s1);
        case (op)
            0: r = (x == y);
            1: r = (x != y);
            2: r = (x <  y);
            3: r = (x <= y);
            4: r = (x >  y);
            default: r = (x >= y);
        endcase
        return r ^ inv;
    endfunction

    // Scoreboard: expectations queued at accept, compared when each result is taken.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 7; k++) sbq[k].delete();
        end else begin
            for (int k = 0; k < 7; k++) begin
                if (ov[k] && rdy) begin
                    checks++;
                    if (sbq[k].size() == 0) begin
                        errors++;
                        $display("FAIL sb%0d_extra got %0b expected no result", k, od[k]);
                    end else begin
                        mexp = sbq[k].pop_front();
                        if (od[k] !== mexp) begin
                            errors++;
                            $display("FAIL sb%0d_data got %0b expected %0b", k, od[k], mexp);
                        end
                    end
                    if (k == 0) pops0++;
                end
                if (v0 && v1 && rd0[k] && rd1[k]) sbq[k].push_back(ecur[k]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic [6:0] xe);
        bit ok;
        ok = 0;
        a = xa; b = xb; ecur = xe; v0 = 1'b1; v1 = 1'b1;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (rd0[0]) ok = 1;
        end
        @(posedge clk);
        #1;
        chk("accept", 32'(ok), 32'd1);
    endtask

    task automatic idle();
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    initial begin
        int t0, base;
        logic [15:0] ra, rb;
        logic [6:0]  re;

        rdy = 1'b1; v0 = 1'b1; v1 = 1'b1; a = 16'h5A; b = 16'h5A;
        #12;
        chk("rst_valid", 32'(ov), 32'h0);
        chk("rst_ready0", 32'(rd0), 32'h0);
        chk("rst_ready1", 32'(rd1), 32'h0);
        @(posedge clk); #1;
        idle();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_valid", 32'(ov), 32'h0);

        // Single transactions: result valid exactly one cycle after accept.
        send(vt[0].a, vt[0].b, vt[0].e);
        idle();
        @(negedge clk);
        chk("latency_v0", 32'(ov), 32'h7F);
        send(vt[1].a, vt[1].b, vt[1].e);
        idle();
        @(negedge clk);
        chk("latency_v1", 32'(ov), 32'h7F);
        for (int i = 2; i < 8; i++) send(vt[i].a, vt[i].b, vt[i].e);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("drained", 32'(ov), 32'h0);

        // Join: a lone valid operand is never consumed.
        @(posedge clk); #1;
        v0 = 1'b1; v1 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("join_only0_rd0", 32'(rd0), 32'h0);
            chk("join_only0_rd1", 32'(rd1), 32'h0);
        end
        @(posedge clk); #1;
        v0 = 1'b0; v1 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("join_only1_rd0", 32'(rd0), 32'h0);
        end
        @(posedge clk); #1;
        idle();

        // Backpressure: two results fill the buffer, the third pair stalls.
        rdy = 1'b0;
        send(vt[0].a, vt[0].b, vt[0].e);
        send(vt[1].a, vt[1].b, vt[1].e);
        a = vt[2].a; b = vt[2].b; ecur = vt[2].e; v0 = 1'b1; v1 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", 32'(rd0), 32'h0);
            chk("bp_valid", 32'(ov), 32'h7F);
            chk("bp_hold", 32'(od), 32'(vt[0].e));
        end
        @(posedge clk); #1;
        rdy = 1'b1;
        @(negedge clk);
        chk("full_no_push", 32'(rd0), 32'h0);
        t0 = cyc;
        send(vt[2].a, vt[2].b, vt[2].e);
        chk("bp_accept_cycle", 32'(cyc - t0), 32'd2);
        idle();
        repeat (4) @(posedge clk);
        #1;

        // Throughput: 100 back-to-back pairs, one accept per cycle.
        base = pops0;
        t0 = cyc;
        for (int i = 0; i < 100; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            for (int k = 0; k < 7; k++) re[k] = model(k, ra, rb);
            send(ra, rb, re);
        end
        chk("tput_cycles", 32'(cyc - t0), 32'd100);
        idle();
        @(posedge clk); #1;
        chk("tput_results", 32'(pops0 - base), 32'd100);
        @(negedge clk);
        chk("tput_drained", 32'(ov), 32'h0);

        // Asynchronous reset with a full buffer.
        @(posedge clk); #1;
        rdy = 1'b0;
        send(vt[6].a, vt[6].b, vt[6].e);
        send(vt[7].a, vt[7].b, vt[7].e);
        idle();
        @(negedge clk);
        chk("pre_rst_valid", 32'(ov), 32'h7F);
        #2;
        a = vt[3].a; b = vt[3].b; v0 = 1'b1; v1 = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(ov), 32'h0);
        chk("rst_async_rd0", 32'(rd0), 32'h0);
        chk("rst_async_rd1", 32'(rd1), 32'h0);
        idle();
        rdy = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_empty", 32'(ov), 32'h0);
        send(vt[4].a, vt[4].b, vt[4].e);
        idle();
        @(negedge clk);
        chk("post_rst_valid", 32'(ov), 32'h7F);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 7; k++) chk($sformatf("sb%0d_empty", k), 32'(sbq[k].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
